// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: operation codes and FSM state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe; the ALU is the slave, the producer/consumer the master.
interface alu_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int OPCODE = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  data_in1;
    logic [WIDTH-1:0]  data_in2;
    logic [OPCODE-1:0] op_code;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  data_out;
    logic              carry_out;
    logic              zero_flag;
    logic              slt_flag;
    logic              busy;

    modport slave (
        input  in_valid, data_in1, data_in2, op_code, out_ready,
        output in_ready, out_valid, data_out, carry_out, zero_flag, slt_flag, busy
    );

    modport master (
        output in_valid, data_in1, data_in2, op_code, out_ready,
        input  in_ready, out_valid, data_out, carry_out, zero_flag, slt_flag, busy
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: latches operands on start, retires one multiplier bit per cycle,
// and holds the product with done high until the next start.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic               busy,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               done_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
            done_q   <= 1'b0;
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign busy    = (cnt_q != '0);
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshakes; MUL is handed to an iterative multiplier
// while the FSM blocks new operands until the product reaches the output register.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int OPCODE = 3
) (
    input logic   clk,
    input logic   rst,
    alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic                slt_q, slt_d;
    logic                mul_slt_q, mul_slt_d;

    logic [OPCODE-1:0]   op_raw;
    alu_op_e             op;
    logic [WIDTH-1:0]    a, b;
    logic [WIDTH:0]      sum, diff;
    logic [2*WIDTH-1:0]  shl;
    logic [SHW-1:0]      shamt;
    logic [WIDTH-1:0]    res;
    logic                res_carry;
    logic                slt;
    logic                accept, consume, in_ready;
    logic                mul_start, mul_done, mul_busy;
    logic [2*WIDTH-1:0]  mul_product;

    assign op_raw = bus.op_code;
    assign op     = alu_op_e'(op_raw);
    assign a      = bus.data_in1;
    assign b      = bus.data_in2;
    assign shamt  = b[SHW-1:0];
    assign slt    = ($signed(a) < $signed(b));

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        shl       = {{WIDTH{1'b0}}, a} << shamt;
        res       = '0;
        res_carry = 1'b0;
        unique case (op)
            ALU_ADD: begin res = sum[WIDTH-1:0];  res_carry = sum[WIDTH];  end
            ALU_SUB: begin res = diff[WIDTH-1:0]; res_carry = diff[WIDTH]; end
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_SLT: res = {{(WIDTH-1){1'b0}}, slt};
            // Bit WIDTH of the widened shift is the last bit pushed out of the result.
            ALU_SLL: begin res = shl[WIDTH-1:0]; res_carry = (shamt != '0) && shl[WIDTH]; end
            ALU_MUL: res = '0;
        endcase
    end

    assign consume  = out_valid_q && bus.out_ready;
    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        out_valid_d = consume ? 1'b0 : out_valid_q;
        data_d      = data_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        slt_d       = slt_q;
        mul_slt_d   = mul_slt_q;
        mul_start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && op == ALU_MUL) begin
                    mul_start = 1'b1;
                    mul_slt_d = slt;
                    state_d   = ST_MUL;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    data_d      = res;
                    carry_d     = res_carry;
                    zero_d      = (res == '0);
                    slt_d       = slt;
                end
            end
            ST_MUL: begin
                // The finished product waits here until the output register is free.
                if (mul_done && (!out_valid_q || bus.out_ready)) begin
                    out_valid_d = 1'b1;
                    data_d      = mul_product[WIDTH-1:0];
                    carry_d     = |mul_product[2*WIDTH-1:WIDTH];
                    zero_d      = (mul_product[WIDTH-1:0] == '0);
                    slt_d       = mul_slt_q;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            slt_q       <= 1'b0;
            mul_slt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            slt_q       <= slt_d;
            mul_slt_q   <= mul_slt_d;
        end
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .busy    (mul_busy),
        .product (mul_product)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;
    assign bus.carry_out = carry_q;
    assign bus.zero_flag = zero_q;
    assign bus.slt_flag  = slt_q;
    assign bus.busy      = mul_busy;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8; expected values are hand-computed.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   busy_cycles;
    int   stray_valid;

    alu_pipe_if #(.WIDTH(WIDTH), .OPCODE(3)) bus ();

    alu_pipe #(.WIDTH(WIDTH), .OPCODE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input alu_op_e op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        bus.in_valid = 1'b1;
        bus.op_code  = op;
        bus.data_in1 = x;
        bus.data_in2 = y;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_code   = '0;
        bus.data_in1  = '0;
        bus.data_in2  = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_flags", {bus.carry_out, bus.zero_flag, bus.slt_flag}, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", bus.in_ready, 1);

        send(ALU_ADD, 8'd255, 8'd255);
        check("add_valid", bus.out_valid, 1);
        check("add_data", bus.data_out, 254);
        check("add_carry", bus.carry_out, 1);
        check("add_zero", bus.zero_flag, 0);

        send(ALU_SUB, 8'd40, 8'd50);
        check("sub_data", bus.data_out, 246);
        check("sub_borrow", bus.carry_out, 1);
        check("sub_slt", bus.slt_flag, 1);
        send(ALU_SUB, 8'd30, 8'd30);
        check("sub_eq_data", bus.data_out, 0);
        check("sub_eq_zero", bus.zero_flag, 1);
        check("sub_eq_carry", bus.carry_out, 0);
        tick();
        check("drain_valid", bus.out_valid, 0);

        send(ALU_MUL, 8'd20, 8'd13);
        bus.in_valid = 1'b1;
        bus.op_code  = ALU_ADD;
        busy_cycles  = 0;
        for (int i = 0; i < WIDTH + 1; i++) begin
            check("mul_in_ready", bus.in_ready, 0);
            check("mul_no_valid", bus.out_valid, 0);
            busy_cycles += int'(bus.busy);
            tick();
        end
        bus.in_valid = 1'b0;
        check("mul_busy_cycles", busy_cycles, WIDTH);
        check("mul_valid", bus.out_valid, 1);
        check("mul_data", bus.data_out, 4);
        check("mul_carry", bus.carry_out, 1);
        check("mul_busy_done", bus.busy, 0);
        tick();
        check("mul_consumed", bus.out_valid, 0);

        send(ALU_XOR, 8'hF0, 8'h3C);
        check("xor_valid", bus.out_valid, 1);
        check("xor_data", bus.data_out, 8'hCC);
        send(ALU_OR, 8'hA0, 8'h05);
        check("or_valid", bus.out_valid, 1);
        check("or_data", bus.data_out, 8'hA5);
        send(ALU_SLL, 8'd1, 8'd7);
        check("sll_valid", bus.out_valid, 1);
        check("sll_data", bus.data_out, 128);
        check("sll_carry", bus.carry_out, 0);
        tick();

        bus.out_ready = 1'b0;
        send(ALU_ADD, 8'd10, 8'd10);
        bus.in_valid = 1'b1;
        bus.op_code  = ALU_SUB;
        bus.data_in1 = 8'd9;
        bus.data_in2 = 8'd3;
        for (int i = 0; i < 5; i++) begin
            check("hold_data", bus.data_out, 20);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_valid", bus.out_valid, 1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        check("chain_valid", bus.out_valid, 1);
        check("chain_data", bus.data_out, 6);
        tick();
        check("chain_drained", bus.out_valid, 0);

        send(ALU_MUL, 8'd7, 8'd7);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.out_valid, 0);
        check("abort_data", bus.data_out, 0);
        tick();
        rst = 1'b0;
        stray_valid = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            stray_valid += int'(bus.out_valid);
        end
        check("abort_no_result", stray_valid, 0);
        send(ALU_ADD, 8'd1, 8'd1);
        check("after_abort_valid", bus.out_valid, 1);
        check("after_abort_data", bus.data_out, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width; legal values are 4 to 64.
REQ-002 Parameter OPCODE, default 3, sets the op_code width; only the value 3 is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  an operand set is presented.
REQ-006 in_ready  output  1  the block can accept an operand set this cycle.
REQ-007 data_in1, data_in2  input  WIDTH each  operands.
REQ-008 op_code  input  OPCODE  operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 MUL.
REQ-009 out_valid  output  1  the result register holds an unconsumed result.
REQ-010 out_ready  input  1  the consumer takes the result.
REQ-011 data_out  output  WIDTH  registered result.
REQ-012 carry_out, zero_flag, slt_flag  output  1 each  registered flags belonging to data_out.
REQ-013 busy  output  1  high while a MUL is iterating.

Function
REQ-014 A transfer SHALL occur on a rising edge where in_valid and in_ready are both high; the output is consumed on an edge where out_valid and out_ready are both high.
REQ-015 in_ready SHALL equal (state == IDLE) and (not out_valid, or out_ready).
- This gives one result per cycle for single-cycle ops while out_ready is held high.
REQ-016 FSM states SHALL be IDLE and MUL.
- IDLE to MUL: a MUL op is accepted.
- MUL to IDLE: after WIDTH iterations, when the product is loaded into the output register.
- All other ops stay in IDLE.
REQ-017 Non-MUL ops SHALL have latency 1: out_valid rises on the edge that accepts the operands, and the result is visible in the following cycle.
REQ-018 MUL SHALL be a shift-add iteration, one multiplier bit per cycle.
- Operands are latched at acceptance.
- out_valid rises on the edge WIDTH+1 cycles after acceptance.
- busy is high for exactly those WIDTH cycles.
REQ-019 ADD: data_out = (a+b) mod 2^WIDTH; carry_out = bit WIDTH of the sum.
REQ-020 SUB: data_out = (a-b) mod 2^WIDTH; carry_out = 1 when a < b unsigned (borrow).
REQ-021 AND, OR, XOR: bitwise result; carry_out = 0.
REQ-022 SLT: data_out = 1 if a < b signed, otherwise 0; carry_out = 0.
REQ-023 SLL: data_out = a shifted left by b[clog2(WIDTH)-1:0]; carry_out = the last bit shifted out, or 0 when the shift amount is 0.
REQ-024 MUL: data_out = low WIDTH bits of the unsigned product; carry_out = 1 when the high WIDTH bits are nonzero.
REQ-025 For every op, zero_flag SHALL be (data_out == 0) and slt_flag SHALL be (a < b signed), using the accepted operands.
REQ-026 While out_valid = 1 and out_ready = 0, data_out and all flags SHALL hold stable.
REQ-027 A MUL that completes while out_valid = 1 and out_ready = 0 SHALL stay in MUL with the product held until the output register frees.
REQ-028 Consume and accept on the same edge SHALL load the new result with out_valid staying 1, and no bubble.
REQ-029 Inputs SHALL be ignored whenever in_ready = 0.

Reset
REQ-030 rst high SHALL immediately force state to IDLE and clear out_valid, busy, data_out, carry_out, zero_flag, slt_flag and the multiplier registers to 0.
REQ-031 Reset during a MUL SHALL abort it; no result is produced.
REQ-032 in_ready SHALL be 1 from the first edge after rst deasserts.

Structure
REQ-033 Package alu_pkg SHALL hold the op_code constants (ALU_ADD to ALU_MUL) and the FSM state encoding.
REQ-034 The iterative multiplier SHALL be a sub-module, alu_mul_seq.
- Interface: start, a, b, done, product (2*WIDTH bits).
- Same clk and rst as the parent.
REQ-035 All combinational op logic SHALL live in alu_pipe.

Verification (WIDTH=8)
REQ-036 The bench SHALL cover the following directed scenarios:
- ADD 255+255 with out_ready=1 -> next cycle data_out=254, carry_out=1, zero_flag=0.
- SUB 40-50 -> data_out=246, carry_out=1, slt_flag=1; then SUB 30-30 -> data_out=0, zero_flag=1.
- MUL 20*13 -> busy for 8 cycles, in_ready=0 meanwhile, out_valid 9 cycles after acceptance, data_out=4, carry_out=1.
- Back-to-back XOR, OR, SLL(1,7) with out_ready=1 -> three results on consecutive cycles; the SLL result is data_out=128, carry_out=0.
- out_ready=0 for 5 cycles after ADD 10+10 -> data_out=20 held, in_ready=0; when out_ready=1 the next op is accepted the same edge.
- rst pulse 3 cycles into MUL 7*7 -> all outputs 0, out_valid never asserts for it; a following ADD 1+1 returns 2.
